btb_predictor: RTL and testbench

//  Direct-mapped branch target buffer with 2-bit direction counters in the IF stage.

---
 rtl/btb_predictor.sv | 190 +++++++++++++++++++
 tb/tb_btb_predictor.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/btb_predictor.sv
// btb_predictor: direct-mapped branch target buffer with 2-bit direction
// counters, looked up combinationally by the fetch PC and trained from the
// decode-stage resolution.
//
// Optional feature macro: BTB_FWD_EN
//   defined   -> a same-cycle update to the looked-up index is bypassed to the
//                lookup (the fetch side sees the entry as it is being written).
//   undefined -> the lookup always sees the table contents from before the
//                current edge; a new value is visible from the next cycle.
//
// Update handshake: upd_valid is a single-cycle strobe with no back-pressure.
// Every cycle in which upd_valid is high is consumed at the next posedge clk
// unless inv_all is high in the same cycle, in which case the update is
// dropped. There is no ready signal; upstream holds if_pc during stalls.
module btb_predictor #(
  parameter int ENTRIES    = 64,
  parameter int ADDR_WIDTH = 32,
  parameter int TAG_BITS   = 8,
  localparam int IDX_BITS  = $clog2(ENTRIES),
  localparam int OCC_W     = IDX_BITS + 1,
  localparam int TAG_LO    = IDX_BITS + 2,
  localparam int TAG_HI    = IDX_BITS + TAG_BITS + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] if_pc,
  output logic                  pred_is_branch,
  output logic                  pred_taken,
  output logic [ADDR_WIDTH-1:0] pred_target,
  input  logic                  upd_valid,
  input  logic [ADDR_WIDTH-1:0] upd_pc,
  input  logic                  upd_is_branch,
  input  logic                  upd_is_jump,
  input  logic                  upd_taken,
  input  logic [ADDR_WIDTH-1:0] upd_target,
  input  logic                  inv_all,
  output logic [IDX_BITS:0]     occupancy
);

  // Table storage, one element per entry.
  logic                  valid_q  [ENTRIES];
  logic [TAG_BITS-1:0]   tag_q    [ENTRIES];
  logic [ADDR_WIDTH-1:0] target_q [ENTRIES];
  logic [1:0]            ctr_q    [ENTRIES];
  logic                  jump_q   [ENTRIES];
  logic [OCC_W-1:0]      occ_q;
  logic [OCC_W-1:0]      occ_d;

  // Address decomposition for both ports.
  logic [IDX_BITS-1:0] lk_idx;
  logic [TAG_BITS-1:0] lk_tag;
  logic [IDX_BITS-1:0] upd_idx;
  logic [TAG_BITS-1:0] upd_tag;

  assign lk_idx  = if_pc[IDX_BITS+1:2];
  assign lk_tag  = if_pc[TAG_HI:TAG_LO];
  assign upd_idx = upd_pc[IDX_BITS+1:2];
  assign upd_tag = upd_pc[TAG_HI:TAG_LO];

  // PC bits outside the index/tag fields take no part in the lookup.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{if_pc[ADDR_WIDTH-1:TAG_HI+1], if_pc[1:0],
                            upd_pc[ADDR_WIDTH-1:TAG_HI+1], upd_pc[1:0]};

  // Post-update image of the entry addressed by upd_pc.
  logic                  upd_hit;
  logic                  new_valid;
  logic [TAG_BITS-1:0]   new_tag;
  logic [ADDR_WIDTH-1:0] new_target;
  logic [1:0]            new_ctr;
  logic                  new_jump;
  logic                  occ_inc;
  logic                  occ_dec;

  assign upd_hit = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);

  // Compute what the resolved instruction does to its entry.
  always_comb begin
    new_valid  = valid_q[upd_idx];
    new_tag    = tag_q[upd_idx];
    new_target = target_q[upd_idx];
    new_ctr    = ctr_q[upd_idx];
    new_jump   = jump_q[upd_idx];
    occ_inc    = 1'b0;
    occ_dec    = 1'b0;
    if (upd_is_branch) begin
      new_valid  = 1'b1;
      new_tag    = upd_tag;
      new_target = upd_target;
      new_jump   = upd_is_jump;
      if (upd_hit) begin
        if (upd_taken) begin
          new_ctr = (ctr_q[upd_idx] == 2'b11) ? 2'b11 : ctr_q[upd_idx] + 2'b01;
        end else begin
          new_ctr = (ctr_q[upd_idx] == 2'b00) ? 2'b00 : ctr_q[upd_idx] - 2'b01;
        end
      end else begin
        // Allocation: replacing a different-tag occupant keeps the count.
        if (upd_is_jump) begin
          new_ctr = 2'b11;
        end else if (upd_taken) begin
          new_ctr = 2'b10;
        end else begin
          new_ctr = 2'b01;
        end
        occ_inc = !valid_q[upd_idx];
      end
    end else if (upd_hit) begin
      new_valid = 1'b0;
      occ_dec   = 1'b1;
    end
  end

  // Occupancy next state; inv_all wins over any same-cycle update.
  always_comb begin
    occ_d = occ_q;
    if (inv_all) begin
      occ_d = '0;
    end else if (upd_valid) begin
      if (occ_inc && (occ_q != OCC_W'(ENTRIES))) begin
        occ_d = occ_q + OCC_W'(1);
      end else if (occ_dec && (occ_q != '0)) begin
        occ_d = occ_q - OCC_W'(1);
      end
    end
  end

  // Table and occupancy registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= 2'b01;
        jump_q[i]   <= 1'b0;
      end
      occ_q <= '0;
    end else begin
      occ_q <= occ_d;
      if (inv_all) begin
        // Only valid bits are cleared; tag/target/ctr contents survive.
        for (int i = 0; i < ENTRIES; i++) begin
          valid_q[i] <= 1'b0;
        end
      end else if (upd_valid) begin
        valid_q[upd_idx]  <= new_valid;
        tag_q[upd_idx]    <= new_tag;
        target_q[upd_idx] <= new_target;
        ctr_q[upd_idx]    <= new_ctr;
        jump_q[upd_idx]   <= new_jump;
      end
    end
  end

  // Entry seen by the lookup, optionally bypassed from the write port.
  logic                  lk_valid;
  logic [TAG_BITS-1:0]   lk_entry_tag;
  logic [ADDR_WIDTH-1:0] lk_target;
  logic [1:0]            lk_ctr;
  logic                  lk_jump;

  // Select table contents or the in-flight update for the fetch lookup.
  always_comb begin
    lk_valid     = valid_q[lk_idx];
    lk_entry_tag = tag_q[lk_idx];
    lk_target    = target_q[lk_idx];
    lk_ctr       = ctr_q[lk_idx];
    lk_jump      = jump_q[lk_idx];
`ifdef BTB_FWD_EN
    if (upd_valid && !inv_all && (upd_idx == lk_idx)) begin
      lk_valid     = new_valid;
      lk_entry_tag = new_tag;
      lk_target    = new_target;
      lk_ctr       = new_ctr;
      lk_jump      = new_jump;
    end
`endif
  end

  logic lk_hit;
  // Reset masks the bypass path so outputs read as a miss during reset.
  assign lk_hit = lk_valid && (lk_entry_tag == lk_tag) && !rst;

  assign pred_is_branch = lk_hit;
  assign pred_taken     = lk_hit && (lk_ctr[1] || lk_jump);
  assign pred_target    = lk_hit ? lk_target : '0;
  assign occupancy      = occ_q;

endmodule

// File: tb/tb_btb_predictor.sv
// tb_btb_predictor: directed test of btb_predictor with ENTRIES=64,
// TAG_BITS=8 (index = pc[7:2], tag = pc[15:8]).
module tb_btb_predictor;

  logic        clk;
  logic        rst;
  logic [31:0] if_pc;
  logic        pred_is_branch;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_is_branch;
  logic        upd_is_jump;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic        inv_all;
  logic [6:0]  occupancy;

  int vectors;
  int miscompares;

  btb_predictor dut (
    .clk            (clk),
    .rst            (rst),
    .if_pc          (if_pc),
    .pred_is_branch (pred_is_branch),
    .pred_taken     (pred_taken),
    .pred_target    (pred_target),
    .upd_valid      (upd_valid),
    .upd_pc         (upd_pc),
    .upd_is_branch  (upd_is_branch),
    .upd_is_jump    (upd_is_jump),
    .upd_taken      (upd_taken),
    .upd_target     (upd_target),
    .inv_all        (inv_all),
    .occupancy      (occupancy)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver: one resolution (and optional inv_all) applied across one edge.
  task automatic do_update(input logic [31:0] pc, input logic br, input logic jmp,
                           input logic tk, input logic [31:0] tgt, input logic inv);
    @(negedge clk);
    upd_valid     = 1'b1;
    upd_pc        = pc;
    upd_is_branch = br;
    upd_is_jump   = jmp;
    upd_taken     = tk;
    upd_target    = tgt;
    inv_all       = inv;
    @(posedge clk);
    #1;
    upd_valid = 1'b0;
    inv_all   = 1'b0;
  endtask

  // Driver: inv_all alone.
  task automatic do_inv_all();
    @(negedge clk);
    inv_all = 1'b1;
    @(posedge clk);
    #1;
    inv_all = 1'b0;
  endtask

  // Driver: present a fetch PC and let the combinational lookup settle.
  task automatic lookup(input logic [31:0] pc);
    if_pc = pc;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    upd_valid = 1'b0; upd_pc = '0; upd_is_branch = 1'b0; upd_is_jump = 1'b0;
    upd_taken = 1'b0; upd_target = '0; inv_all = 1'b0; if_pc = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    lookup(32'h0040_0100);
    vectors++; if (pred_is_branch !== 1'b0) begin miscompares++; $display("FAIL reset_hit: got %0b want 0", pred_is_branch); end
    vectors++; if (pred_taken !== 1'b0) begin miscompares++; $display("FAIL reset_taken: got %0b want 0", pred_taken); end
    vectors++; if (pred_target !== 32'h0) begin miscompares++; $display("FAIL reset_target: got %h want 0", pred_target); end
    vectors++; if (occupancy !== 7'd0) begin miscompares++; $display("FAIL reset_occ: got %0d want 0", occupancy); end
  endtask

  task automatic test_train();
    do_update(32'h0040_0100, 1'b1, 1'b0, 1'b1, 32'h0040_0200, 1'b0);
    lookup(32'h0040_0100);
    vectors++; if (pred_is_branch !== 1'b1) begin miscompares++; $display("FAIL train_hit: got %0b want 1", pred_is_branch); end
    vectors++; if (pred_taken !== 1'b1) begin miscompares++; $display("FAIL train_taken: got %0b want 1", pred_taken); end
    vectors++; if (pred_target !== 32'h0040_0200) begin miscompares++; $display("FAIL train_target: got %h want 00400200", pred_target); end
    vectors++; if (occupancy !== 7'd1) begin miscompares++; $display("FAIL train_occ: got %0d want 1", occupancy); end
    // 10 -> 01
    do_update(32'h0040_0100, 1'b1, 1'b0, 1'b0, 32'h0040_0200, 1'b0);
    lookup(32'h0040_0100);
    vectors++; if (pred_taken !== 1'b0) begin miscompares++; $display("FAIL train_wnt: got %0b want 0", pred_taken); end
    // 01 -> 00 -> 00 (saturated)
    do_update(32'h0040_0100, 1'b1, 1'b0, 1'b0, 32'h0040_0200, 1'b0);
    do_update(32'h0040_0100, 1'b1, 1'b0, 1'b0, 32'h0040_0200, 1'b0);
    lookup(32'h0040_0100);
    vectors++; if (pred_taken !== 1'b0) begin miscompares++; $display("FAIL train_snt: got %0b want 0", pred_taken); end
    // 00 -> 01: still not taken only if the counter did not wrap
    do_update(32'h0040_0100, 1'b1, 1'b0, 1'b1, 32'h0040_0200, 1'b0);
    lookup(32'h0040_0100);
    vectors++; if (pred_taken !== 1'b0) begin miscompares++; $display("FAIL train_sat_low: got %0b want 0", pred_taken); end
    // 01 -> 10 -> 11 -> 11, then one not-taken -> 10 (still taken)
    do_update(32'h0040_0100, 1'b1, 1'b0, 1'b1, 32'h0040_0200, 1'b0);
    do_update(32'h0040_0100, 1'b1, 1'b0, 1'b1, 32'h0040_0200, 1'b0);
    do_update(32'h0040_0100, 1'b1, 1'b0, 1'b1, 32'h0040_0200, 1'b0);
    do_update(32'h0040_0100, 1'b1, 1'b0, 1'b0, 32'h0040_0200, 1'b0);
    lookup(32'h0040_0100);
    vectors++; if (pred_taken !== 1'b1) begin miscompares++; $display("FAIL train_sat_high: got %0b want 1", pred_taken); end
    vectors++; if (occupancy !== 7'd1) begin miscompares++; $display("FAIL train_occ_hold: got %0d want 1", occupancy); end
  endtask

  task automatic test_jump();
    // Index 0, tag 0x03: replaces the 0x0040_0100 entry.
    do_update(32'h0040_0300, 1'b1, 1'b1, 1'b0, 32'h0040_0800, 1'b0);
    lookup(32'h0040_0300);
    vectors++; if (pred_is_branch !== 1'b1) begin miscompares++; $display("FAIL jump_hit: got %0b want 1", pred_is_branch); end
    vectors++; if (pred_taken !== 1'b1) begin miscompares++; $display("FAIL jump_taken: got %0b want 1", pred_taken); end
    vectors++; if (pred_target !== 32'h0040_0800) begin miscompares++; $display("FAIL jump_target: got %h want 00400800", pred_target); end
    vectors++; if (occupancy !== 7'd1) begin miscompares++; $display("FAIL jump_occ: got %0d want 1", occupancy); end
    lookup(32'h0040_0100);
    vectors++; if (pred_is_branch !== 1'b0) begin miscompares++; $display("FAIL jump_old_miss: got %0b want 0", pred_is_branch); end
    // Retrain as conditional not-taken: 11 -> 10 (taken), 10 -> 01 (not taken, jump bit gone)
    do_update(32'h0040_0300, 1'b1, 1'b0, 1'b0, 32'h0040_0800, 1'b0);
    lookup(32'h0040_0300);
    vectors++; if (pred_taken !== 1'b1) begin miscompares++; $display("FAIL jump_ctr10: got %0b want 1", pred_taken); end
    do_update(32'h0040_0300, 1'b1, 1'b0, 1'b0, 32'h0040_0800, 1'b0);
    lookup(32'h0040_0300);
    vectors++; if (pred_taken !== 1'b0) begin miscompares++; $display("FAIL jump_cleared: got %0b want 0", pred_taken); end
  endtask

  task automatic test_alias();
    // Both at index 1; tags pc[15:8] = 0x01 and 0x11.
    do_update(32'h0040_0104, 1'b1, 1'b0, 1'b1, 32'h0040_0A00, 1'b0);
    vectors++; if (occupancy !== 7'd2) begin miscompares++; $display("FAIL alias_occ_alloc: got %0d want 2", occupancy); end
    do_update(32'h0040_1104, 1'b1, 1'b0, 1'b0, 32'h0040_0B00, 1'b0);
    vectors++; if (occupancy !== 7'd2) begin miscompares++; $display("FAIL alias_occ_replace: got %0d want 2", occupancy); end
    lookup(32'h0040_0104);
    vectors++; if (pred_is_branch !== 1'b0) begin miscompares++; $display("FAIL alias_old_miss: got %0b want 0", pred_is_branch); end
    lookup(32'h0040_1104);
    vectors++; if (pred_is_branch !== 1'b1) begin miscompares++; $display("FAIL alias_new_hit: got %0b want 1", pred_is_branch); end
    vectors++; if (pred_taken !== 1'b0) begin miscompares++; $display("FAIL alias_new_taken: got %0b want 0", pred_taken); end
    vectors++; if (pred_target !== 32'h0040_0B00) begin miscompares++; $display("FAIL alias_new_target: got %h want 00400b00", pred_target); end
  endtask

  task automatic test_invalidate();
    do_update(32'h0040_1104, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    lookup(32'h0040_1104);
    vectors++; if (pred_is_branch !== 1'b0) begin miscompares++; $display("FAIL inv_miss: got %0b want 0", pred_is_branch); end
    vectors++; if (occupancy !== 7'd1) begin miscompares++; $display("FAIL inv_occ: got %0d want 1", occupancy); end
    // Non-branch on a miss changes nothing.
    do_update(32'h0040_1104, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    vectors++; if (occupancy !== 7'd1) begin miscompares++; $display("FAIL inv_nochange_occ: got %0d want 1", occupancy); end
    // inv_all with an allocating update: update dropped.
    do_update(32'h0040_0208, 1'b1, 1'b0, 1'b1, 32'h0040_0C00, 1'b1);
    vectors++; if (occupancy !== 7'd0) begin miscompares++; $display("FAIL invall_occ: got %0d want 0", occupancy); end
    lookup(32'h0040_0208);
    vectors++; if (pred_is_branch !== 1'b0) begin miscompares++; $display("FAIL invall_dropped: got %0b want 0", pred_is_branch); end
    lookup(32'h0040_0300);
    vectors++; if (pred_is_branch !== 1'b0) begin miscompares++; $display("FAIL invall_cleared: got %0b want 0", pred_is_branch); end
  endtask

  task automatic test_fill();
    for (int i = 0; i < 64; i++) begin
      do_update(32'h0050_0000 + 32'(i * 4), 1'b1, 1'b0, 1'b1, 32'h0060_0000 + 32'(i), 1'b0);
    end
    vectors++; if (occupancy !== 7'd64) begin miscompares++; $display("FAIL fill_occ: got %0d want 64", occupancy); end
    lookup(32'h0050_00FC);
    vectors++; if (pred_target !== 32'h0060_003F) begin miscompares++; $display("FAIL fill_last_target: got %h want 0060003f", pred_target); end
    // Replacement in a full table keeps the count at 64.
    do_update(32'h0050_1000, 1'b1, 1'b0, 1'b1, 32'h0070_0000, 1'b0);
    vectors++; if (occupancy !== 7'd64) begin miscompares++; $display("FAIL fill_replace_occ: got %0d want 64", occupancy); end
    do_inv_all();
    vectors++; if (occupancy !== 7'd0) begin miscompares++; $display("FAIL fill_invall_occ: got %0d want 0", occupancy); end
  endtask

  task automatic test_same_cycle();
    logic exp_hit;
    // Allocate at index 5 with lookup of the same PC in the same cycle.
    @(negedge clk);
    if_pc = 32'h0040_0114;
    upd_valid = 1'b1; upd_pc = 32'h0040_0114; upd_is_branch = 1'b1; upd_is_jump = 1'b0;
    upd_taken = 1'b1; upd_target = 32'h0040_0D00; inv_all = 1'b0;
    #1;
`ifdef BTB_FWD_EN
    exp_hit = 1'b1;
`else
    exp_hit = 1'b0;
`endif
    vectors++; if (pred_is_branch !== exp_hit) begin miscompares++; $display("FAIL same_alloc_hit: got %0b want %0b", pred_is_branch, exp_hit); end
    vectors++; if (pred_target !== (exp_hit ? 32'h0040_0D00 : 32'h0)) begin miscompares++; $display("FAIL same_alloc_target: got %h", pred_target); end
    @(posedge clk);
    #1 upd_valid = 1'b0;
    vectors++; if (pred_is_branch !== 1'b1) begin miscompares++; $display("FAIL same_after_hit: got %0b want 1", pred_is_branch); end
    // Same-cycle invalidate of that entry.
    @(negedge clk);
    upd_valid = 1'b1; upd_is_branch = 1'b0;
    #1;
    vectors++; if (pred_is_branch !== !exp_hit) begin miscompares++; $display("FAIL same_inv_hit: got %0b want %0b", pred_is_branch, !exp_hit); end
    @(posedge clk);
    #1 upd_valid = 1'b0;
    vectors++; if (pred_is_branch !== 1'b0) begin miscompares++; $display("FAIL same_inv_after: got %0b want 0", pred_is_branch); end
    vectors++; if (occupancy !== 7'd0) begin miscompares++; $display("FAIL same_inv_occ: got %0d want 0", occupancy); end
  endtask

  task automatic test_reset_mid();
    do_update(32'h0040_0118, 1'b1, 1'b0, 1'b1, 32'h0040_0E00, 1'b0);
    lookup(32'h0040_0118);
    vectors++; if (pred_is_branch !== 1'b1) begin miscompares++; $display("FAIL rmid_pre_hit: got %0b want 1", pred_is_branch); end
    // Update to index 7 in flight, then reset while clk is low.
    @(negedge clk);
    upd_valid = 1'b1; upd_pc = 32'h0040_011C; upd_is_branch = 1'b1; upd_is_jump = 1'b1;
    upd_taken = 1'b1; upd_target = 32'h0040_0F00;
    #2 rst = 1'b1;
    #1;
    vectors++; if (pred_is_branch !== 1'b0) begin miscompares++; $display("FAIL rmid_hit: got %0b want 0", pred_is_branch); end
    vectors++; if (pred_target !== 32'h0) begin miscompares++; $display("FAIL rmid_target: got %h want 0", pred_target); end
    vectors++; if (occupancy !== 7'd0) begin miscompares++; $display("FAIL rmid_occ: got %0d want 0", occupancy); end
    @(posedge clk);
    #1;
    upd_valid = 1'b0;
    rst = 1'b0;
    lookup(32'h0040_011C);
    vectors++; if (pred_is_branch !== 1'b0) begin miscompares++; $display("FAIL rmid_lost: got %0b want 0", pred_is_branch); end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_train();
    test_jump();
    test_alias();
    test_invalidate();
    test_fill();
    test_same_cycle();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
